// File: rtl/game_pkg.sv
// Shared definitions between the move front-end and gameController:
// direction codes, the idle direction value and the scheduler state encoding.
package game_pkg;

    localparam logic [2:0] UP       = 3'd0;
    localparam logic [2:0] RIGHT    = 3'd1;
    localparam logic [2:0] DOWN     = 3'd2;
    localparam logic [2:0] LEFT     = 3'd3;
    localparam logic [2:0] DIR_NONE = 3'd4;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } sched_state_t;

    // Index of the lowest set bit; callers guarantee at least one bit is set.
    function automatic logic [1:0] lowest_set(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchronizer, stability counter and one-cycle rising-edge pulse for
// a single raw button. The debounced level resets to 0.
module button_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic press
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                // This is the DEBOUNCE_CYCLES-th consecutive differing sample.
                cnt   <= '0;
                level <= sync2;
                press <= sync2;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/move_scheduler.sv
// Debounces the direction and new-game buttons, queues moves in a small FIFO
// and issues them to gameController spaced by the board update window.
module move_scheduler
    import game_pkg::*;
#(
    parameter int unsigned MOVE_CYCLES     = 42,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned FIFO_DEPTH      = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [3:0]                    btn,
    input  logic                          btn_new,
    output logic [2:0]                    dir,
    output logic                          game_rst,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   pending,
    output logic                          drop
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CNTW = PW + 1;

    logic [3:0]    dir_press;
    logic          new_press;

    for (genvar i = 0; i < 4; i++) begin : g_dir_btn
        button_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk  (clk),
            .rst_n(rst_n),
            .raw  (btn[i]),
            .press(dir_press[i])
        );
    end

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_new (
        .clk  (clk),
        .rst_n(rst_n),
        .raw  (btn_new),
        .press(new_press)
    );

    logic [1:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CNTW-1:0] count;

    sched_state_t    state;
    logic [7:0]      wait_cnt;

    logic            any_press;
    logic            multi_press;
    logic [1:0]      win_code;
    logic            full;
    logic            pop;
    logic            push;

    always_comb begin
        any_press   = |dir_press;
        multi_press = (dir_press & (dir_press - 4'd1)) != 4'd0;
        win_code    = lowest_set(dir_press);
        full        = count == CNTW'(FIFO_DEPTH);
        // A new-game event takes priority: no pop, and presses vanish silently.
        pop         = (state == IDLE) && (count != '0) && !new_press;
        push        = any_press && !new_press && (!full || pop);
        drop        = any_press && !new_press && (multi_press || (full && !pop));
        busy        = (state != IDLE) || (count != '0);
        pending     = count;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= win_code;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (new_press) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CNTW'(1);
                2'b01:   count <= count - CNTW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wait_cnt <= '0;
            dir      <= DIR_NONE;
            game_rst <= 1'b0;
        end else begin
            game_rst <= new_press;
            dir      <= DIR_NONE;
            if (new_press) begin
                state    <= IDLE;
                wait_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (pop) begin
                            dir   <= {1'b0, mem[rd_ptr]};
                            state <= ISSUE;
                        end
                    end
                    ISSUE: begin
                        wait_cnt <= 8'(MOVE_CYCLES - 1);
                        state    <= WAIT;
                    end
                    WAIT: begin
                        // Leaving on the decrement to zero keeps ISSUE-to-ISSUE at MOVE_CYCLES+1.
                        wait_cnt <= wait_cnt - 8'd1;
                        if (wait_cnt == 8'd1) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_move_scheduler.sv
// Directed bench for move_scheduler: expected dir pulses and game_rst pulses are
// queued by the stimulus and checked by an independent negedge monitor.
module tb_move_scheduler;

    localparam int unsigned MC = 42;
    localparam int unsigned DC = 4;
    localparam int unsigned FD = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] btn;
    logic       btn_new;
    logic [2:0] dir;
    logic       game_rst;
    logic       busy;
    logic [2:0] pending;
    logic       drop;

    typedef struct {
        int code;
        int gap;
    } exp_t;

    exp_t exp_q[$];

    int n_tests    = 0;
    int n_fail     = 0;
    int cyc        = 0;
    int last_pulse = -1000;
    int drop_seen  = 0;
    int pend_max   = 0;
    int rst_seen   = 0;
    int rst_exp    = 0;

    move_scheduler #(
        .MOVE_CYCLES    (MC),
        .DEBOUNCE_CYCLES(DC),
        .FIFO_DEPTH     (FD)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn     (btn),
        .btn_new (btn_new),
        .dir     (dir),
        .game_rst(game_rst),
        .busy    (busy),
        .pending (pending),
        .drop    (drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic press(input int code);
        btn[code] = 1'b1;
        step(7);
        btn[code] = 1'b0;
        step(1);
    endtask

    task automatic expect_dir(input int code, input int gap);
        exp_t e;
        e.code = code;
        e.gap  = gap;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle(input string name, input int bound);
        int k;
        k = 0;
        while (busy && k < bound) begin
            step(1);
            k++;
        end
        check(name, int'(busy), 0);
    endtask

    // Monitor: pops the scoreboard on every dir pulse and checks game_rst side effects.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n) begin
                if (int'(pending) > pend_max) pend_max = int'(pending);
                if (drop) drop_seen++;
                if (dir != 3'd4) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_dir", int'(dir), 4);
                    end else begin
                        e = exp_q.pop_front();
                        check("dir_code", int'(dir), e.code);
                        if (e.gap != 0) check("dir_spacing", cyc - last_pulse, e.gap);
                    end
                    last_pulse = cyc;
                end
                if (game_rst) begin
                    rst_seen++;
                    check("game_rst_pending", int'(pending), 0);
                    check("game_rst_busy", int'(busy), 0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int k;

        rst_n   = 1'b0;
        btn     = 4'b0000;
        btn_new = 1'b0;
        step(3);
        check("reset_dir", int'(dir), 4);
        check("reset_game_rst", int'(game_rst), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_pending", int'(pending), 0);
        check("reset_drop", int'(drop), 0);
        rst_n = 1'b1;
        step(2);

        // Single press: latency DC+4 edges, busy drops MC cycles after the pulse.
        expect_dir(1, 0);
        btn = 4'b0010;
        n = 0;
        do begin
            step(1);
            n++;
        end while (dir == 3'd4 && n < 50);
        check("single_latency", n, DC + 4);
        k = 0;
        do begin
            step(1);
            k++;
        end while (busy && k < 100);
        check("single_busy_window", k, MC);
        btn = 4'b0000;
        step(12);
        check("single_queue_drained", exp_q.size(), 0);

        // Bounce rejection.
        pend_max  = 0;
        drop_seen = 0;
        for (int i = 0; i < 10; i++) begin
            btn[0] = ~btn[0];
            step(2);
        end
        btn[0] = 1'b0;
        step(12);
        check("bounce_pending_max", pend_max, 0);
        check("bounce_busy", int'(busy), 0);
        check("bounce_drop", drop_seen, 0);

        // Simultaneous press: lowest index wins, one drop.
        drop_seen = 0;
        expect_dir(2, 0);
        btn = 4'b1100;
        step(7);
        btn = 4'b0000;
        wait_idle("simul_idle", 100);
        step(10);
        check("simul_drop_count", drop_seen, 1);
        check("simul_queue_drained", exp_q.size(), 0);

        // Queue overflow: presses 8 cycles apart fill the FIFO before the second issue.
        drop_seen = 0;
        pend_max  = 0;
        expect_dir(0, 0);
        expect_dir(1, MC + 1);
        expect_dir(2, MC + 1);
        expect_dir(3, MC + 1);
        expect_dir(0, MC + 1);
        press(0);
        press(1);
        press(2);
        press(3);
        press(0);
        press(1);
        wait_idle("overflow_idle", 400);
        step(10);
        check("overflow_drop_count", drop_seen, 1);
        check("overflow_pending_peak", pend_max, 4);
        check("overflow_queue_drained", exp_q.size(), 0);

        // New game while WAITing with three moves queued.
        expect_dir(0, 0);
        press(0);
        press(1);
        press(2);
        press(3);
        check("newgame_pending_before", int'(pending), 3);
        check("newgame_busy_before", int'(busy), 1);
        rst_exp++;
        btn_new = 1'b1;
        step(8);
        btn_new = 1'b0;
        step(100);
        check("newgame_rst_count", rst_seen, rst_exp);
        check("newgame_pending_after", int'(pending), 0);
        check("newgame_busy_after", int'(busy), 0);
        check("newgame_queue_drained", exp_q.size(), 0);

        // Asynchronous reset during WAIT with two moves pending.
        expect_dir(0, 0);
        press(0);
        press(1);
        press(2);
        check("areset_pending_before", int'(pending), 2);
        check("areset_busy_before", int'(busy), 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("areset_dir", int'(dir), 4);
        check("areset_game_rst", int'(game_rst), 0);
        check("areset_busy", int'(busy), 0);
        check("areset_pending", int'(pending), 0);
        check("areset_drop", int'(drop), 0);
        step(3);
        rst_n = 1'b1;
        step(150);
        check("areset_pending_after", int'(pending), 0);
        check("areset_busy_after", int'(busy), 0);
        check("final_queue_drained", exp_q.size(), 0);
        check("final_rst_count", rst_seen, rst_exp);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
